// File: rtl/rcc_count_sampler.sv
// rcc_count_sampler
// Samples the 4-bit ripple counter into the clk domain, rejects short-lived
// ripple states, extends the count to EXT_W bits by counting 15->0 wraps,
// presents each new value on a valid/ready stream, and sequences a counter
// clear through ctr_reset.
// Optional feature macro: RCC_MATCH_EN (adds the match_val comparator that
// drives match_hit; when undefined match_hit is tied low).
module rcc_count_sampler #(
    parameter int EXT_W      = 12,
    parameter int CLR_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cnt_in,
    input  logic             clr_req,
    output logic             ctr_reset,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXT_W-1:0] out_data,
    output logic             dropped,
    input  logic [EXT_W-1:0] match_val,
    output logic             match_hit
);

    localparam int HI_W  = EXT_W - 4;
    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_CLR_DRIVE,
        ST_CLR_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  r_clrCnt;
    logic [3:0]        r_s1;
    logic [3:0]        r_s2;
    logic [3:0]        r_s3;
    logic [3:0]        r_accLo;
    logic [HI_W-1:0]   r_extHi;
    logic              r_ctrReset;
    logic              r_outValid;
    logic [EXT_W-1:0]  r_outData;
    logic              r_dropped;

    logic              w_stable;
    logic              w_wrap;
    logic              w_update;
    logic              w_clrEntry;
    logic [HI_W-1:0]   w_extHiNext;
    logic [EXT_W-1:0]  w_newValue;

    // Two samples agreeing means the ripple has settled for at least two clocks.
    assign w_stable    = (r_s2 == r_s3);
    assign w_wrap      = (r_s2 < r_accLo);
    assign w_extHiNext = r_extHi + HI_W'(w_wrap);
    assign w_newValue  = {w_extHiNext, r_s2};
    // A clear request takes priority over an update landing on the same edge.
    assign w_update    = (r_state == ST_RUN) && !clr_req && w_stable && (r_s2 != r_accLo);

    // Three-flop synchroniser chain; the last two stages double as the stability filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= cnt_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Clear sequencer state register and the drive-phase cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_clrCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            if (r_state == ST_CLR_DRIVE) begin
                r_clrCnt <= r_clrCnt + CNT_W'(1);
            end else begin
                r_clrCnt <= '0;
            end
        end
    end

    // Next-state logic: hold ctr_reset for CLR_CYCLES, then wait for a settled zero.
    always_comb begin
        w_stateNext = r_state;
        w_clrEntry  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (clr_req) begin
                    w_stateNext = ST_CLR_DRIVE;
                    w_clrEntry  = 1'b1;
                end
            end
            ST_CLR_DRIVE: begin
                if (r_clrCnt == CLR_LAST) begin
                    w_stateNext = ST_CLR_WAIT;
                end
            end
            ST_CLR_WAIT: begin
                if (w_stable && (r_s2 == 4'd0)) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    // ctr_reset comes straight from a flop so the counter never sees a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrReset <= 1'b0;
        end else begin
            r_ctrReset <= (w_stateNext == ST_CLR_DRIVE);
        end
    end

    // Accumulator, extension and output stream: latest value wins, overwrites are flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accLo    <= '0;
            r_extHi    <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_dropped  <= 1'b0;
        end else if (w_clrEntry) begin
            r_accLo    <= '0;
            r_extHi    <= '0;
            r_outValid <= 1'b0;
            r_dropped  <= 1'b0;
        end else if (w_update) begin
            r_accLo    <= r_s2;
            r_extHi    <= w_extHiNext;
            r_outData  <= w_newValue;
            r_outValid <= 1'b1;
            if (r_outValid && !out_ready) begin
                r_dropped <= 1'b1;
            end
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

`ifdef RCC_MATCH_EN
    logic r_matchHit;

    // One-cycle pulse alongside the output update whose extended value equals match_val.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_matchHit <= 1'b0;
        end else begin
            r_matchHit <= w_update && (w_newValue == match_val);
        end
    end

    assign match_hit = r_matchHit;
`else
    logic w_unusedMatch;
    assign w_unusedMatch = ^match_val;
    assign match_hit     = 1'b0;
`endif

    assign ctr_reset = r_ctrReset;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_rcc_count_sampler.sv
// tb_rcc_count_sampler
// Directed bench for rcc_count_sampler with hand-computed expected values.
// Checks both build flavours of match_hit depending on RCC_MATCH_EN.
module tb_rcc_count_sampler;

    logic        clk;
    logic        reset;
    logic [3:0]  cnt_in;
    logic        clr_req;
    logic        ctr_reset;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        dropped;
    logic [11:0] match_val;
    logic        match_hit;

    int   testsRun;
    int   testsFailed;
    logic earlyValid;
    logic expHit;

    rcc_count_sampler #(
        .EXT_W      (12),
        .CLR_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .clr_req   (clr_req),
        .ctr_reset (ctr_reset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dropped   (dropped),
        .match_val (match_val),
        .match_hit (match_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive a new counter value and wait the three-edge latency plus one;
    // earlyValid records whether out_valid rose too soon.
    task automatic applyStimulus(input logic [3:0] v);
        cnt_in     = v;
        earlyValid = 1'b0;
        repeat (3) begin
            tick();
            earlyValid = earlyValid | out_valid;
        end
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cnt_in    = 4'd0;
        clr_req   = 1'b0;
        out_ready = 1'b1;
        match_val = 12'hABC;
        idle(2);
        testsRun++;
        if ({ctr_reset, out_valid, dropped, match_hit} !== 4'b0000 || out_data !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: ctr=%b valid=%b drop=%b hit=%b data=%h, expected all 0",
                     ctr_reset, out_valid, dropped, match_hit, out_data);
        end
        reset = 1'b0;
        idle(4);
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_event: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_count();
        for (int v = 1; v <= 5; v++) begin
            applyStimulus(4'(v));
            testsRun++;
            if (earlyValid !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'(v)) begin
                testsFailed++;
                $display("[TB] FAIL count_%0d: early=%b valid=%b data=%h, expected early=0 valid=1 data=%h",
                         v, earlyValid, out_valid, out_data, 12'(v));
            end
            idle(4);
            testsRun++;
            if (out_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL count_consumed_%0d: out_valid=%b expected 0", v, out_valid);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  vals [4];
        logic [11:0] exps [4];
        int          total;
        vals = '{4'd14, 4'd15, 4'd0, 4'd1};
        exps = '{12'h00E, 12'h00F, 12'h010, 12'h011};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vals[i]);
            testsRun++;
            if (out_valid !== 1'b1 || out_data !== exps[i]) begin
                testsFailed++;
                $display("[TB] FAIL wrap_step_%0d: valid=%b data=%h, expected valid=1 data=%h",
                         i, out_valid, out_data, exps[i]);
            end
            idle(4);
        end
        // Walk the running total up to 0xFFF in steps of 7, then cross to 0x000.
        total = 17;
        while (total + 7 <= 4095) begin
            total += 7;
            applyStimulus(4'(total % 16));
            testsRun++;
            if (out_valid !== 1'b1 || out_data !== 12'(total)) begin
                testsFailed++;
                $display("[TB] FAIL sweep_%0d: valid=%b data=%h, expected %h",
                         total, out_valid, out_data, 12'(total));
            end
            idle(1);
        end
        applyStimulus(4'd15);
        testsRun++;
        if (out_data !== 12'hFFF) begin
            testsFailed++;
            $display("[TB] FAIL wrap_FFF: data=%h expected FFF", out_data);
        end
        idle(4);
        applyStimulus(4'd0);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL wrap_000: valid=%b data=%h expected valid=1 data=000", out_valid, out_data);
        end
        idle(4);
    endtask

    task automatic test_glitch();
        applyStimulus(4'd7);
        testsRun++;
        if (out_data !== 12'h007) begin
            testsFailed++;
            $display("[TB] FAIL glitch_pre: data=%h expected 007", out_data);
        end
        idle(4);
        cnt_in = 4'd6;
        tick();
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL glitch_hold: out_valid=%b expected 0", out_valid);
        end
        applyStimulus(4'd8);
        testsRun++;
        if (earlyValid !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'h008) begin
            testsFailed++;
            $display("[TB] FAIL glitch_filter: early=%b valid=%b data=%h, expected early=0 valid=1 data=008",
                     earlyValid, out_valid, out_data);
        end
        idle(4);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        applyStimulus(4'd1);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 12'h011 || dropped !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_first: valid=%b data=%h drop=%b, expected 1/011/0",
                     out_valid, out_data, dropped);
        end
        idle(4);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 12'h011) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold: valid=%b data=%h, expected 1/011", out_valid, out_data);
        end
        applyStimulus(4'd2);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 12'h012 || dropped !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_overwrite: valid=%b data=%h drop=%b, expected 1/012/1",
                     out_valid, out_data, dropped);
        end
        out_ready = 1'b1;
        tick();
        testsRun++;
        if (out_valid !== 1'b0 || dropped !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_transfer: valid=%b drop=%b, expected 0/1", out_valid, dropped);
        end
    endtask

    task automatic test_clear();
        int highCycles;
        logic sawValid;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        testsRun++;
        if (ctr_reset !== 1'b1 || out_valid !== 1'b0 || dropped !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_entry: ctr=%b valid=%b drop=%b, expected 1/0/0",
                     ctr_reset, out_valid, dropped);
        end
        highCycles = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ctr_reset !== 1'b1) break;
            highCycles++;
        end
        testsRun++;
        if (highCycles != 4) begin
            testsFailed++;
            $display("[TB] FAIL clr_width: ctr_reset high %0d cycles, expected 4", highCycles);
        end
        // Still in the wait phase with a non-zero count: requests and events are ignored.
        clr_req  = 1'b1;
        sawValid = 1'b0;
        tick();
        clr_req = 1'b0;
        repeat (6) begin
            tick();
            sawValid = sawValid | out_valid | ctr_reset;
        end
        testsRun++;
        if (sawValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_wait_quiet: valid/ctr seen=%b expected 0", sawValid);
        end
        cnt_in = 4'd0;
        repeat (8) begin
            tick();
            sawValid = sawValid | out_valid;
        end
        testsRun++;
        if (sawValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_zero_silent: out_valid seen=%b expected 0", sawValid);
        end
        applyStimulus(4'd3);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 12'h003 || dropped !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_resume: valid=%b data=%h drop=%b, expected 1/003/0",
                     out_valid, out_data, dropped);
        end
        idle(4);
    endtask

    task automatic test_match();
`ifdef RCC_MATCH_EN
        expHit = 1'b1;
`else
        expHit = 1'b0;
`endif
        match_val = 12'h013;
        applyStimulus(4'd10);
        testsRun++;
        if (out_data !== 12'h00A || match_hit !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL match_miss: data=%h hit=%b, expected 00A/0", out_data, match_hit);
        end
        idle(4);
        applyStimulus(4'd3);
        testsRun++;
        if (out_data !== 12'h013 || match_hit !== expHit) begin
            testsFailed++;
            $display("[TB] FAIL match_hit: data=%h hit=%b, expected 013/%b", out_data, match_hit, expHit);
        end
        tick();
        testsRun++;
        if (match_hit !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL match_pulse: hit=%b expected 0", match_hit);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        testsRun++;
        if (ctr_reset !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midclr_active: ctr=%b expected 1", ctr_reset);
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if (ctr_reset !== 1'b0 || out_valid !== 1'b0 || out_data !== 12'h000 || dropped !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midclr_reset: ctr=%b valid=%b data=%h drop=%b, expected 0/0/000/0",
                     ctr_reset, out_valid, out_data, dropped);
        end
        tick();
        cnt_in = 4'd0;
        reset  = 1'b0;
        idle(4);
        applyStimulus(4'd1);
        testsRun++;
        if (out_valid !== 1'b1 || out_data !== 12'h001) begin
            testsFailed++;
            $display("[TB] FAIL midclr_run: valid=%b data=%h, expected 1/001", out_valid, out_data);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_count();
        test_wrap();
        test_glitch();
        test_backpressure();
        test_clear();
        test_match();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
